// File: rtl/pwm_compare.sv
// pwm_compare: turns samples of an upstream free-running counter into a
// registered PWM waveform. It classifies every count step (hold, normal,
// wrap, restart, jump) and swaps in newly requested duty values only at a
// period boundary, so no PWM period is ever torn.
module pwm_compare #(
  parameter int WIDTH = 8,
  parameter int WRAPW = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] duty_in,
  input  logic             duty_valid,
  output logic             duty_ready,
  input  logic             err_clr,
  output logic             pwm_out,
  output logic             wrap_pulse,
  output logic             restart_pulse,
  output logic             jump_err,
  output logic [WRAPW-1:0] wrap_count
);

  localparam logic [WIDTH-1:0] MAX_VAL  = '1;
  localparam logic [WIDTH-1:0] ZERO_VAL = '0;
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);
  localparam logic [WRAPW-1:0] WC_MAX   = '1;
  localparam logic [WRAPW-1:0] WC_ONE   = WRAPW'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_RUN
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_pending;
  logic [WIDTH-1:0] r_active;
  logic             r_act_valid;
  logic             r_pwm;
  logic             r_wrap_pulse;
  logic             r_restart_pulse;
  logic             r_jump_err;
  logic [WRAPW-1:0] r_wrap_count;

  logic             w_hold;
  logic             w_normal;
  logic             w_wrap;
  logic             w_restart;
  logic             w_jump;
  logic             w_boundary;
  logic             w_handshake;
  logic             w_apply_pending;
  logic [WIDTH-1:0] w_eff_duty;
  logic             w_eff_valid;
  logic             w_pwm_next;

  // Step classification of the current sample against the previous one.
  // Wrap is carved out of "normal" because max+1 also lands on zero.
  assign w_hold     = (value == r_prev);
  assign w_wrap     = (r_prev == MAX_VAL) && (value == ZERO_VAL);
  assign w_normal   = (value == (r_prev + ONE_VAL)) && !w_wrap;
  assign w_restart  = (value == ZERO_VAL) && (r_prev != ZERO_VAL) && (r_prev != MAX_VAL);
  assign w_jump     = !(w_hold || w_normal || w_wrap || w_restart);
  assign w_boundary = w_wrap || w_restart;

  assign duty_ready  = (r_state != ST_SYNC);
  assign w_handshake = duty_valid && duty_ready;

  // A pending duty becomes effective on the very boundary sample, so the new
  // period starts with the new duty (and is valid even when coming from IDLE).
  assign w_apply_pending = (r_state == ST_SYNC) && w_boundary;
  assign w_eff_duty      = w_apply_pending ? r_pending : r_active;
  assign w_eff_valid     = w_apply_pending || r_act_valid;
  assign w_pwm_next      = w_eff_valid && (value < w_eff_duty);

  // Duty handshake FSM: capture into pending, promote to active on a boundary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_pending   <= '0;
      r_active    <= '0;
      r_act_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_pending <= duty_in;
            r_state   <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (w_boundary) begin
            r_active    <= r_pending;
            r_act_valid <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_handshake) begin
            r_pending <= duty_in;
            r_state   <= ST_SYNC;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sample history, PWM compare and one-cycle event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev          <= MAX_VAL;
      r_pwm           <= 1'b0;
      r_wrap_pulse    <= 1'b0;
      r_restart_pulse <= 1'b0;
    end else begin
      r_prev          <= value;
      r_pwm           <= w_pwm_next;
      r_wrap_pulse    <= w_wrap;
      r_restart_pulse <= w_restart;
    end
  end

  // Sticky jump flag (set beats clear) and saturating wrap counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_jump_err   <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      if (w_jump) begin
        r_jump_err <= 1'b1;
      end else if (err_clr) begin
        r_jump_err <= 1'b0;
      end
      if (w_wrap && (r_wrap_count != WC_MAX)) begin
        r_wrap_count <= r_wrap_count + WC_ONE;
      end
    end
  end

  assign pwm_out       = r_pwm;
  assign wrap_pulse    = r_wrap_pulse;
  assign restart_pulse = r_restart_pulse;
  assign jump_err      = r_jump_err;
  assign wrap_count    = r_wrap_count;

endmodule

// File: tb/tb_pwm_compare.sv
// Testbench for pwm_compare: directed scenarios plus randomized counter
// streams. A driver issues stimulus and pushes the expected next-cycle
// outputs from a behavioural model; a monitor pops and compares each cycle.
module tb_pwm_compare;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic [7:0] duty_in;
  logic       duty_valid;
  logic       err_clr;

  logic        pwm_a, wp_a, rp_a, je_a, rdy_a;
  logic [15:0] wc_a;
  logic        pwm_b, wp_b, rp_b, je_b, rdy_b;
  logic [1:0]  wc_b;

  always #5 clk = ~clk;

  pwm_compare #(.WIDTH(8), .WRAPW(16)) dut_a (
    .clk(clk), .reset(reset), .value(value), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(rdy_a), .err_clr(err_clr),
    .pwm_out(pwm_a), .wrap_pulse(wp_a), .restart_pulse(rp_a),
    .jump_err(je_a), .wrap_count(wc_a)
  );

  pwm_compare #(.WIDTH(8), .WRAPW(2)) dut_b (
    .clk(clk), .reset(reset), .value(value), .duty_in(duty_in),
    .duty_valid(duty_valid), .duty_ready(rdy_b), .err_clr(err_clr),
    .pwm_out(pwm_b), .wrap_pulse(wp_b), .restart_pulse(rp_b),
    .jump_err(je_b), .wrap_count(wc_b)
  );

  typedef struct {
    bit pwm;
    bit wp;
    bit rp;
    bit je;
    bit rdy;
    int wc;
    int wcs;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state
  int m_prev;
  bit m_has_pend;
  int m_pend;
  bit m_act_on;
  int m_act;
  bit m_jump;
  int m_wraps;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_prev     = 255;
    m_has_pend = 0;
    m_pend     = 0;
    m_act_on   = 0;
    m_act      = 0;
    m_jump     = 0;
    m_wraps    = 0;
  endtask

  task automatic model_step(input int vi, input bit dv, input int din, input bit clr);
    exp_t e;
    bit hs   = dv && !m_has_pend;
    bit bnd  = (vi == 0) && (m_prev != 0);
    bit wr   = bnd && (m_prev == 255);
    bit jmp  = (vi != 0) && (vi != m_prev) && (vi != m_prev + 1);
    bit on;
    int d;
    if (bnd && m_has_pend) begin
      on = 1;
      d  = m_pend;
    end else begin
      on = m_act_on;
      d  = m_act;
    end
    e.pwm = on && (vi < d);
    e.wp  = wr;
    e.rp  = bnd && !wr;
    if (bnd && m_has_pend) begin
      m_act      = m_pend;
      m_act_on   = 1;
      m_has_pend = 0;
    end
    if (hs) begin
      m_pend     = din;
      m_has_pend = 1;
      $display("txn t=%0t duty accept 0x%02h at value 0x%02h", $time, din, vi);
    end
    if (jmp) m_jump = 1;
    else if (clr) m_jump = 0;
    if (wr) m_wraps++;
    m_prev = vi;
    e.je  = m_jump;
    e.rdy = !m_has_pend;
    e.wc  = (m_wraps > 65535) ? 65535 : m_wraps;
    e.wcs = (m_wraps > 3) ? 3 : m_wraps;
    q.push_back(e);
  endtask

  task automatic step(input int v, input bit dv, input int din, input bit clr);
    @(negedge clk);
    reset      = 1'b1;
    value      = 8'(v);
    duty_valid = dv;
    duty_in    = 8'(din);
    err_clr    = clr;
    model_step(v, dv, din, clr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pwm"}, int'(pwm_a), 0);
    chk({tag, "_wrap_pulse"}, int'(wp_a), 0);
    chk({tag, "_restart_pulse"}, int'(rp_a), 0);
    chk({tag, "_jump_err"}, int'(je_a), 0);
    chk({tag, "_wrap_count"}, int'(wc_a), 0);
    chk({tag, "_duty_ready"}, int'(rdy_a), 1);
    chk({tag, "_wrap_count_small"}, int'(wc_b), 0);
  endtask

  // Monitor: every cycle the DUT presents a new registered output set.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        mon_e = q.pop_front();
        chk("pwm_out", int'(pwm_a), int'(mon_e.pwm));
        chk("wrap_pulse", int'(wp_a), int'(mon_e.wp));
        chk("restart_pulse", int'(rp_a), int'(mon_e.rp));
        chk("jump_err", int'(je_a), int'(mon_e.je));
        chk("duty_ready", int'(rdy_a), int'(mon_e.rdy));
        chk("wrap_count", int'(wc_a), mon_e.wc);
        chk("wrap_count_w2", int'(wc_b), mon_e.wcs);
        chk("pwm_out_w2", int'(pwm_b), int'(mon_e.pwm));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int cur;
    int r;
    int nv;
    int k;
    int din;
    int sendat;
    reset      = 1'b0;
    value      = 8'h00;
    duty_in    = 8'h00;
    duty_valid = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    model_reset();

    // Duty 0x40 accepted in IDLE on a wrap cycle; applied at the next wrap.
    step(0, 1, 8'h40, 0);
    for (int v = 1; v < 256; v++) step(v, 0, 0, 0);
    for (int v = 0; v < 256; v++) step(v, 0, 0, 0);
    // In RUN at 0x40, request 0xC0 at 0x80; next period uses 0xC0.
    for (int v = 0; v < 256; v++) step(v, (v == 8'h80), 8'hC0, 0);
    for (int v = 0; v < 256; v++) step(v, 0, 0, 0);
    // Pending duty applied at a restart 0x37 -> 0x00.
    for (int v = 0; v <= 8'h37; v++) step(v, (v == 8'h10), 8'h20, 0);
    for (int v = 0; v <= 8'h10; v++) step(v, 0, 0, 0);
    // Jump 0x10 -> 0x20, hold, clear, and clear colliding with a new jump.
    step(8'h20, 0, 0, 0);
    step(8'h21, 0, 0, 0);
    step(8'h22, 0, 0, 1);
    step(8'h23, 0, 0, 0);
    step(8'h40, 0, 0, 1);
    step(8'h41, 0, 0, 1);
    // Stall at 0x05 for 10 cycles.
    for (int v = 0; v <= 5; v++) step(v, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(5, 0, 0, 0);
    // Full periods with random duty requests (boundary duties included).
    for (int p = 0; p < 4; p++) begin
      sendat = $urandom_range(0, 255);
      k = $urandom_range(0, 3);
      din = (k == 0) ? 0 : (k == 1) ? 255 : $urandom_range(0, 255);
      for (int v = 0; v < 256; v++) step(v, (v == sendat), din, 0);
    end
    cur = 255;

    // Randomized counter stream.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 78)      nv = (cur + 1) % 256;
      else if (r < 88) nv = cur;
      else if (r < 93) nv = 0;
      else if (r < 96) nv = $urandom_range(0, 255);
      else             nv = $urandom_range(8'hF8, 8'hFF);
      k = $urandom_range(0, 9);
      din = (k == 0) ? 0 : (k == 1) ? 255 : $urandom_range(0, 255);
      step(nv, ($urandom_range(0, 4) == 0), din, ($urandom_range(0, 9) == 0));
      cur = nv;
    end

    // Asynchronous reset in the middle of a period, checked without a clock edge.
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    begin
      exp_t e0;
      e0.pwm = 0; e0.wp = 0; e0.rp = 0; e0.je = 0; e0.rdy = 1; e0.wc = 0; e0.wcs = 0;
      q.push_back(e0);
    end
    cur = 255;
    for (int i = 0; i < 300; i++) begin
      nv = ($urandom_range(0, 9) == 0) ? cur : (cur + 1) % 256;
      step(nv, ($urandom_range(0, 7) == 0), $urandom_range(0, 255), 0);
      cur = nv;
    end

    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_compare.md
# pwm_compare

Downstream consumer of the free-running 8-bit counter's `value` output. It compares each count sample against a duty threshold and produces a registered PWM waveform. It also classifies every count step as normal, hold, wrap, restart or jump, so period boundaries and counter misbehaviour are visible. New duty values are accepted over a valid/ready handshake and take effect only at a period boundary, so the PWM never emits a torn period.

## Interface
- `WIDTH`, 8: width of `value` and duty.
- `WRAPW`, 16: width of the wrap counter.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; asserted when 0.
- `value` in WIDTH: count sample from the upstream counter, sampled every cycle.
- `duty_in` in WIDTH: requested duty threshold.
- `duty_valid` in 1: `duty_in` is valid.
- `duty_ready` out 1: block can accept a duty.
- `err_clr` in 1: clears `jump_err`.
- `pwm_out` out 1: PWM output.
- `wrap_pulse` out 1: one-cycle pulse per wrap (max to 0).
- `restart_pulse` out 1: one-cycle pulse per restart (non-max, non-zero to 0).
- `jump_err` out 1: sticky flag for an illegal step.
- `wrap_count` out WRAPW: number of wraps seen, saturating.

## Operation
- `prev` register holds the last sample. Reset value is all ones, so a first sample of 0 after reset counts as a boundary.
- Step classes, evaluated on the current `value` against `prev`; exactly one applies:
  - **hold**: `value == prev`.
  - **normal**: `value == prev+1`, mod 2^WIDTH, excluding max→0.
  - **wrap**: `prev == max` and `value == 0`.
  - **restart**: `value == 0` and `prev` is neither 0 nor max. The initial all-ones `prev` counts as max, so the first 0 after reset is a wrap.
  - **jump**: anything else.
- boundary = wrap or restart.
- State machine:
  - **IDLE**: no active duty.
  - **SYNC**: a pending duty waits for a boundary.
  - **RUN**: active duty in use, nothing pending.
- Transitions:
  - IDLE→SYNC on handshake.
  - SYNC→RUN on boundary; pending is copied to active.
  - RUN→SYNC on handshake; the old active duty stays in force.
- `duty_ready` = 1 in IDLE and RUN, 0 in SYNC. A handshake is `duty_valid & duty_ready`, and `duty_in` is captured into pending.
- Handshake in IDLE on a boundary cycle: the duty goes to pending and waits for the next boundary.
- Effective duty for a sample: pending if state is SYNC and the sample is a boundary, else active.
- `pwm_out` next value = active-valid & (`value` < effective duty), unsigned compare. Active-valid is 0 in IDLE and also in SYNC when entered from IDLE.
  - duty 0 gives constantly low.
  - duty max gives low only on `value == max`.
- `wrap_count` increments on wrap and saturates at 2^WRAPW−1. Restarts do not count.
- `jump_err` sets on jump and clears on `err_clr`. When both occur in the same cycle, set wins.
- Reset mid-operation: all state cleared immediately and asynchronously, including pending and active duty. The block returns to IDLE.

## Timing
- Reset values:
  - `pwm_out`, `wrap_pulse`, `restart_pulse`, `jump_err` = 0.
  - `wrap_count` = 0.
  - `duty_ready` = 1 (IDLE).
  - `prev` = all ones.
- All outputs are registered; latency is 1 cycle from the `value` sample to `pwm_out` and the pulses.
- `duty_ready` is a decode of registered state. It deasserts the cycle after the accepting edge and reasserts the cycle after the boundary edge.
- Pulses are high for exactly one cycle per event. Consecutive events give back-to-back pulses.
- Hold cycles (counter stalled) produce no pulses and do not change state.
- Reset deassertion is synchronised by the integrator. The block only requires `reset` to be stable around `clk` edges.

## Test plan
- Reset, then duty 0x40 handshake in IDLE, counter runs 0x00..0xFF → `duty_ready` drops; on the next 0xFF→0x00 the state becomes RUN; `pwm_out` is high for values 0x00–0x3F (64 cycles, one-cycle lag) and low for 192.
- In RUN at duty 0x40, send 0xC0 while the counter is at 0x80 → the rest of the current period stays at 0x40; the next period is high for 192 cycles; `duty_ready` stays low from accept until the wrap.
- Counter reset mid-period (0x37→0x00), then resumes → `restart_pulse` for 1 cycle, `wrap_pulse` stays 0, `wrap_count` unchanged, pending duty applied at that restart.
- Counter jumps 0x10→0x20 → `jump_err`=1 held; `err_clr` clears it; `err_clr` in the same cycle as a new jump leaves it at 1.
- Counter held at 0x05 for 10 cycles (stall) → no pulses, `pwm_out` steady, state unchanged.
- With WRAPW=2, five wraps → `wrap_count` = 3 (saturated); async `reset` low mid-period → all outputs 0, `duty_ready`=1 without a clock edge.
